// File: rtl/mult_adder_sched_pkg.sv
// Shared convolution datapath parameters for the multiply/adder scheduler.
package mult_adder_sched_pkg;

    localparam int CONV_MULT_WIDTH = 8;
    localparam int CONV_ADD_WIDTH  = 24;
    localparam int MA_TREE_SIZE    = 64;
    // One capture stage plus one adder level per tree halving.
    localparam int MA_LATENCY      = 1 + $clog2(MA_TREE_SIZE);

    // Requester tag width; a single requester still carries a 1-bit tag.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_adder_sched_fifo.sv
// Result FIFO: data plus requester tag, registered read (no bypass), count out.
module mult_adder_sched_fifo #(
    parameter int DATA_W = 24,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         do_push, do_pop;

    // Pointer/count update; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        data_d  = data_q;
        tag_d   = tag_q;
        if (do_push) begin
            data_d[wr_q] = push_data;
            tag_d[wr_q]  = push_tag;
        end
        wr_d  = wr_q + PTR_W'(do_push);
        rd_d  = rd_q + PTR_W'(do_pop);
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            tag_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? data_q[rd_q] : '0;
    assign out_tag   = out_valid ? tag_q[rd_q] : '0;
    assign count     = cnt_q;

endmodule

// File: rtl/mult_adder_sched.sv
// Round-robin issue of window/kernel jobs into the shared fixed-latency
// multiply/adder tree, with a tag/bias side pipeline and a credit-guarded
// result FIFO so results are never dropped under backpressure.
module mult_adder_sched
    import mult_adder_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TREE_SIZE  = MA_TREE_SIZE,
    parameter int LATENCY    = MA_LATENCY,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ*TREE_SIZE*CONV_MULT_WIDTH-1:0] req_in,
    input  logic [NUM_REQ*TREE_SIZE*CONV_MULT_WIDTH-1:0] req_kernel,
    input  logic [NUM_REQ*CONV_ADD_WIDTH-1:0]            req_bias,
    output logic [TREE_SIZE*CONV_MULT_WIDTH-1:0]         ma_in,
    output logic [TREE_SIZE*CONV_MULT_WIDTH-1:0]         ma_kernel,
    output logic [CONV_ADD_WIDTH-1:0]                    ma_bias,
    input  logic [CONV_ADD_WIDTH-1:0]                    ma_out,
    output logic                                         res_valid,
    input  logic                                         res_ready,
    output logic [CONV_ADD_WIDTH-1:0]                    res_data,
    output logic [tag_width(NUM_REQ)-1:0]                res_tag,
    output logic                                         busy
);
    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int OPW   = TREE_SIZE * CONV_MULT_WIDTH;
    localparam int AW    = CONV_ADD_WIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [TAG_W-1:0]               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]               inflight_q, inflight_d;
    logic [LATENCY:1]               vld_pipe_q, vld_pipe_d;
    logic [LATENCY:1][TAG_W-1:0]    tag_pipe_q, tag_pipe_d;
    logic [LATENCY:1][AW-1:0]       bias_pipe_q, bias_pipe_d;
    logic [CNT_W-1:0]               fifo_count;
    logic                           credit_ok, issue, push;
    logic [TAG_W-1:0]               gnt_idx, idx;
    logic [AW-1:0]                  issue_bias;

    // Every job in flight or buffered holds one FIFO slot, so issue needs a free one.
    assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

    // Round-robin search starting after the last granted lane; no grant while in reset.
    always_comb begin
        issue     = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        req_ready = '0;
        if (reset && credit_ok) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = TAG_W'((int'(last_grant_q) + 1 + i) % NUM_REQ);
                if (!issue && req_valid[idx]) begin
                    issue   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        if (issue) req_ready[gnt_idx] = 1'b1;
        last_grant_d = issue ? gnt_idx : last_grant_q;
    end

    // Issue mux: granted lane's operands, zeros when idle.
    always_comb begin
        ma_in      = '0;
        ma_kernel  = '0;
        issue_bias = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (issue && (gnt_idx == TAG_W'(k))) begin
                ma_in      = req_in[k*OPW +: OPW];
                ma_kernel  = req_kernel[k*OPW +: OPW];
                issue_bias = req_bias[k*AW +: AW];
            end
        end
    end

    // Side pipeline shadowing the datapath; it never stalls.
    always_comb begin
        vld_pipe_d  = {vld_pipe_q[LATENCY-1:1], issue};
        tag_pipe_d  = {tag_pipe_q[LATENCY-1:1], gnt_idx};
        bias_pipe_d = {bias_pipe_q[LATENCY-1:1], issue_bias};
        push        = vld_pipe_q[LATENCY];
        inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(push);
    end

    // Arbiter pointer, tag pipeline and in-flight counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= TAG_W'(NUM_REQ - 1);
            inflight_q   <= '0;
            vld_pipe_q   <= '0;
            tag_pipe_q   <= '0;
            bias_pipe_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            vld_pipe_q   <= vld_pipe_d;
            tag_pipe_q   <= tag_pipe_d;
            bias_pipe_q  <= bias_pipe_d;
        end
    end

    // Bias meets the tree sum in the result cycle.
    assign ma_bias = push ? bias_pipe_q[LATENCY] : '0;

    mult_adder_sched_fifo #(
        .DATA_W (AW),
        .TAG_W  (TAG_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (ma_out),
        .push_tag  (tag_pipe_q[LATENCY]),
        .pop       (res_ready),
        .out_valid (res_valid),
        .out_data  (res_data),
        .out_tag   (res_tag),
        .count     (fifo_count)
    );

    assign busy = (inflight_q != '0) || res_valid;

endmodule

// File: tb/tb_mult_adder_sched.sv
// Directed + randomized bench for mult_adder_sched with a behavioural
// datapath and a job-queue reference model.
module tb_mult_adder_sched;
    localparam int NR  = 4;
    localparam int TS  = 64;
    localparam int MW  = 8;
    localparam int AW  = 24;
    localparam int OPW = TS * MW;
    localparam int LAT = 7;
    localparam int FD  = 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NR-1:0]        req_valid = '0;
    logic [NR-1:0]        req_ready;
    logic [NR*OPW-1:0]    req_in = '0, req_kernel = '0;
    logic [NR*AW-1:0]     req_bias = '0;
    logic [OPW-1:0]       ma_in, ma_kernel;
    logic [AW-1:0]        ma_bias, ma_out;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [AW-1:0]        res_data;
    logic [1:0]           res_tag;
    logic                 busy;

    mult_adder_sched #(.NUM_REQ(NR), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_in(req_in), .req_kernel(req_kernel), .req_bias(req_bias),
        .ma_in(ma_in), .ma_kernel(ma_kernel), .ma_bias(ma_bias), .ma_out(ma_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [AW-1:0] dot(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        int s;
        s = 0;
        for (int j = 0; j < TS; j++)
            s += int'($signed(a[j*MW +: MW])) * int'($signed(b[j*MW +: MW]));
        return s[AW-1:0];
    endfunction

    // Behavioural shared datapath: sum captured at the edge, out LAT cycles later, bias added at output.
    logic [AW-1:0] dp [LAT];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LAT; k++) dp[k] <= '0;
        end else begin
            dp[0] <= dot(ma_in, ma_kernel);
            for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
        end
    end
    assign ma_out = dp[LAT-1] + ma_bias;

    typedef struct { logic [AW-1:0] d; int tag; int due; } exp_t;
    exp_t q[$];
    int   grant_log[$];
    logic [OPW-1:0] lin [NR];
    logic [OPW-1:0] lker [NR];
    logic [AW-1:0]  lbias [NR];
    int   jobs [NR];
    int   last_m = NR - 1;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   gcount = 0;
    bit   rnd = 0;
    logic [AW-1:0] last_d;
    int   last_t = -1, last_c = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_lane(input int k);
        for (int w = 0; w < OPW/32; w++) begin
            lin[k][w*32 +: 32]  = $urandom();
            lker[k][w*32 +: 32] = $urandom();
        end
        lbias[k] = AW'($urandom());
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            req_valid[k]             = jobs[k] > 0;
            req_in[k*OPW +: OPW]     = lin[k];
            req_kernel[k*OPW +: OPW] = lker[k];
            req_bias[k*AW +: AW]     = lbias[k];
        end
    endtask

    function automatic logic [NR-1:0] exp_grant();
        int idx;
        if (q.size() >= FD) return '0;
        for (int i = 0; i < NR; i++) begin
            idx = (last_m + 1 + i) % NR;
            if (req_valid[idx]) return NR'(1) << idx;
        end
        return '0;
    endfunction

    // One clock: check at the falling edge, advance the model after the rising edge.
    task automatic cycle();
        logic [NR-1:0] x;
        logic          p, erv;
        logic [AW-1:0] pd;
        int            pt;
        @(negedge clock);
        chk("onehot", 64'($onehot0(req_ready)), 64'd1);
        chk("grant", 64'(req_ready), 64'(exp_grant()));
        erv = (q.size() > 0) && (cyc >= q[0].due);
        chk("res_valid", 64'(res_valid), 64'(erv));
        if (erv && res_valid) begin
            chk("res_data", 64'(res_data), 64'(q[0].d));
            chk("res_tag", 64'(res_tag), 64'(q[0].tag));
        end
        chk("busy", 64'(busy), 64'(q.size() != 0));
        x  = req_valid & req_ready;
        p  = res_valid & res_ready;
        pd = res_data;
        pt = int'(res_tag);
        @(posedge clock);
        #1;
        if (p && q.size() > 0) begin
            last_d = pd; last_t = pt; last_c = cyc;
            void'(q.pop_front());
        end
        for (int k = 0; k < NR; k++) begin
            if (x[k]) begin
                q.push_back('{d: dot(lin[k], lker[k]) + lbias[k], tag: k, due: cyc + LAT + 1});
                grant_log.push_back(k);
                last_m = k;
                gcount++;
                jobs[k]--;
                if (rnd) randomize_lane(k);
            end
        end
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_jobs(input int n);
        for (int k = 0; k < NR; k++) jobs[k] = n;
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            lin[k] = '0; lker[k] = '0; lbias[k] = '0; jobs[k] = 0;
        end
        // Reset: outputs idle even with requests pending.
        req_valid = '1;
        #12;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ma_bias", 64'(ma_bias), 64'd0);
        chk("rst_ma_in_zero", 64'(ma_in == '0), 64'd1);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single job on lane 2: 64*1*2 + 5.
        lin[2] = {TS{8'd1}}; lker[2] = {TS{8'd2}}; lbias[2] = 24'd5;
        jobs[2] = 1; res_ready = 1'b1; cyc = 0; drive();
        run(12);
        chk("single_data", 64'(last_d), 64'd133);
        chk("single_tag", 64'(last_t), 64'd2);
        chk("single_cycle", 64'(last_c), 64'd8);

        // Fair arbitration with random operands, full-rate drain.
        rnd = 1;
        for (int k = 0; k < NR; k++) randomize_lane(k);
        grant_log.delete();
        set_jobs(1000); drive();
        run(40);
        for (int i = 1; i < 8; i++)
            chk("rr_order", 64'(grant_log[i]), 64'((grant_log[0] + i) % NR));
        set_jobs(0); drive();
        run(12);

        // Backpressure: exactly FD grants, then resume when released.
        res_ready = 1'b0; gcount = 0;
        set_jobs(1000); drive();
        run(20);
        chk("bp_grants", 64'(gcount), 64'(FD));
        res_ready = 1'b1;
        run(12);
        chk("bp_resume", 64'(gcount > FD), 64'd1);

        // Full FIFO with res_ready toggling.
        res_ready = 1'b0;
        run(12);
        for (int i = 0; i < 40; i++) begin
            res_ready = i[0];
            cycle();
        end
        set_jobs(0); drive(); res_ready = 1'b1;
        run(20);
        chk("drained", 64'(q.size()), 64'd0);

        // Negative operands.
        rnd = 0;
        lin[1] = {TS{8'h80}}; lker[1] = {TS{8'h7F}}; lbias[1] = 24'hFFFFFF;
        jobs[1] = 1; drive();
        run(12);
        chk("neg_data", 64'(last_d), 64'hF01FFF);
        chk("neg_tag", 64'(last_t), 64'd1);

        // Reset mid-flight: two buffered, three in flight.
        res_ready = 1'b0;
        jobs[0] = 1; jobs[2] = 1; drive();
        run(10);
        jobs[1] = 1; jobs[3] = 1; jobs[0] = 1; drive();
        run(3);
        chk("pre_rst_outstanding", 64'(q.size()), 64'd5);
        set_jobs(5); drive();
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_res_data", 64'(res_data), 64'd0);
        chk("mid_rst_res_tag", 64'(res_tag), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ma_bias", 64'(ma_bias), 64'd0);
        chk("mid_rst_ma_in", 64'(ma_in == '0 && ma_kernel == '0), 64'd1);
        q.delete(); last_m = NR - 1;
        set_jobs(0); drive();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_res_valid", 64'(res_valid), 64'd0);
        @(posedge clock);
        #1;
        cyc = 0; grant_log.delete(); res_ready = 1'b1;
        set_jobs(1); drive();
        run(16);
        chk("post_rst_first_lane", 64'(grant_log[0]), 64'd0);
        chk("post_rst_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_adder_sched.md
# mult_adder_sched

Round-robin scheduler that shares one `mult_adder` convolution datapath among `NUM_REQ` requesting lanes. It issues at most one window/kernel job per cycle into the fixed-latency, non-stallable multiply/adder tree. It carries each job's requester tag and bias alongside the pipeline, and buffers results in an output FIFO so that backpressure can never lose a product. The block sits between the window-generation lanes and the convolution result writeback.

## Interface
- `NUM_REQ`, 4: number of requesting lanes (≥2).
- `TREE_SIZE`, `MA_TREE_SIZE` (64): products per job.
- `LATENCY`, 1+log2(`TREE_SIZE`) (7): clock edges from operand capture to valid `ma_out`.
- `FIFO_DEPTH`, 8: result FIFO entries (power of two, ≥ `LATENCY`+1 for full throughput).
- `clock`, in, 1: clock.
- `reset`, in, 1: reset; asynchronous, active-low.
- `req_valid`, in, `NUM_REQ`: job offered per lane.
- `req_ready`, out, `NUM_REQ`: one-hot grant; transfer happens when valid&ready.
- `req_in`, in, `NUM_REQ`*`TREE_SIZE`*`CONV_MULT_WIDTH`: per-lane window operands.
- `req_kernel`, in, same width: per-lane kernel operands.
- `req_bias`, in, `NUM_REQ`*`CONV_ADD_WIDTH`: per-lane bias.
- `ma_in`, `ma_kernel`, out, `TREE_SIZE`*`CONV_MULT_WIDTH`: operands to the datapath.
- `ma_bias`, out, `CONV_ADD_WIDTH`: bias to the datapath, aligned with the result cycle.
- `ma_out`, in, `CONV_ADD_WIDTH`: datapath result (tree sum + bias).
- `res_valid`, out, 1: FIFO non-empty.
- `res_ready`, in, 1: consumer accepts the head entry.
- `res_data`, out, `CONV_ADD_WIDTH`: result.
- `res_tag`, out, clog2(`NUM_REQ`): originating lane.
- `busy`, out, 1: jobs in flight or FIFO non-empty.

## Operation
- **Credit rule.** `credit = FIFO_DEPTH − fifo_count − inflight`. Grant is allowed only if `credit > 0`. This guarantees a FIFO slot for every issued job.
- **Arbitration.** Round-robin, combinational in the issue cycle. Search starts at `last_grant+1` mod `NUM_REQ`. `last_grant` updates only on an actual transfer.
- **Grant behaviour.**
  - `req_ready` is one-hot or zero.
  - `req_ready` never depends on `res_ready` in the same cycle.
  - A lane holding `req_valid` is granted within `NUM_REQ` issue opportunities.
- **Issue mux.** `ma_in` and `ma_kernel` take the granted lane's operands. With no grant they are driven 0, so the datapath computes 0 and no tag is produced.
- **Tag pipeline.** A `LATENCY`-stage shift register of {valid, tag, bias} advances every cycle unconditionally.
  - `ma_bias` is driven from the final stage's bias. It is 0 when that stage is invalid.
  - When the final stage is valid, `ma_out` and its tag are pushed into the FIFO.
- **`inflight`.** Count of valid pipeline stages: +1 on issue, −1 on push.
- **FIFO.**
  - Pop when `res_valid & res_ready`.
  - Simultaneous push and pop keeps the count unchanged, including at full and at empty.
  - No bypass: a push is visible the cycle after.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Arithmetic.** No saturation. `res_data` is `ma_out` truncated to `CONV_ADD_WIDTH`, exactly as the datapath delivers it.

## Timing
- **Reset values.** All outputs 0 during reset. This covers `req_ready`, `ma_in`, `ma_kernel`, `ma_bias`, `res_valid`, `res_data`, `res_tag` and `busy`. `last_grant` resets to `NUM_REQ−1`, so lane 0 wins first.
- **Latency.**
  - Job granted in cycle t.
  - Datapath captures operands at the end of t.
  - `ma_out` is valid in cycle t+`LATENCY`, with `ma_bias` valid in the same cycle.
  - FIFO push occurs at the end of t+`LATENCY`.
  - `res_valid` is high at the earliest in t+`LATENCY`+1.
- **Throughput.** One job per cycle while credit remains. Sustained full rate requires `res_ready` to be held high.
- **Credit boundary.** When credit is 0, all `req_ready` are 0. Credit returns in the cycle after a pop.
- **Reset mid-operation.** Asserting `reset` discards in-flight tags and FIFO contents; the datapath resets simultaneously. No result is emitted for jobs issued before reset.

## Structure
- **Shared package / `network_params.h`.** Holds `CONV_MULT_WIDTH`, `CONV_ADD_WIDTH`, `MA_TREE_SIZE`, the derived `MA_LATENCY`, and the tag width function.
- **Sub-module `mult_adder_sched_fifo`.** A synchronous FIFO with data and tag fields and a count output. Arbiter, tag pipeline and credit logic stay in the top module.
- **Top-level wrapper.** `mult_adder` is not instantiated inside this block; both are instantiated side by side one level up.

## Test plan
- **Single job.** After reset, lane 2 offers all operands = 1, kernel = 2, bias = 5.
  - Required: grant in cycle 0.
  - Required: `res_valid` in cycle 8 with `res_data` = 133 (64·2+5) and `res_tag` = 2.
- **Fair arbitration.** All 4 lanes continuously valid, `res_ready` = 1.
  - Required: grant order 0,1,2,3,0…
  - Required: one result per cycle from cycle 8 onward, with matching tags.
- **Backpressure.** All lanes valid, `res_ready` = 0.
  - Required: exactly 8 grants, then `req_ready` = 0 indefinitely.
  - Required: releasing `res_ready` yields 8 results in order and resumes issue.
- **Full FIFO, simultaneous push/pop.** FIFO full and `res_ready` toggling 1/0.
  - Required: no loss or duplication; the tag sequence matches the issue order.
- **Negative operands.** Operands −128 × 127 on all products, bias −1.
  - Required: `res_data` = −1040385 as a 24-bit two's-complement value (0xF01FFF).
- **Reset mid-flight.** Reset with 3 jobs issued and 2 results buffered.
  - Required: all outputs 0 immediately.
  - Required: after release, `busy` = 0 and no stale result appears; the next grant goes to lane 0.
